// File: rtl/number_pkg.sv
// number_pkg: shared constants and encoder state type for the literal number encoder
package number_pkg;
  localparam int GROUP_W = 5;
  localparam int NIBBLE_W = 4;
  localparam logic [2:0] LIT_TYPE_ID = 3'd4;
  localparam int NUM_W_DEF = 64;
  localparam int MAX_GROUPS = NUM_W_DEF / NIBBLE_W;
  typedef enum logic [1:0] {
    IDLE,
`ifdef LITERAL_HEADER_EN
    HEADER,
`endif
    GROUP
  } enc_state_e;
endpackage

// File: rtl/number_msn_finder.sv
// number_msn_finder: num -> group_count = index of highest non-zero nibble + 1 (minimum 1)
module number_msn_finder
  import number_pkg::*;
#(
  parameter int NUM_W = 64
) (
  input  logic [NUM_W-1:0] num,
  output logic [4:0]       group_count
);
  always_comb begin
    group_count = 5'd1;
    for (int i = 0; i < NUM_W / NIBBLE_W; i++)
      group_count = |num[NIBBLE_W*i +: NIBBLE_W] ? 5'(i + 1) : group_count;
  end
endmodule

// File: rtl/number_encoder.sv
// number_encoder: serialises inNumber into 5-bit literal groups on outBit/outLast (valid/ready both sides); LITERAL_HEADER_EN prefixes a version/type header
module number_encoder
  import number_pkg::*;
#(
  parameter int NUM_W = 64,
  parameter int VERSION_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [NUM_W-1:0]     inNumber,
  input  logic [VERSION_W-1:0] inVersion,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 outBit,
  output logic                 outLast,
  output logic [4:0]           groupCount,
  output logic                 busy
);
  enc_state_e state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [4:0] gc_q, gc_d, grp_q, grp_d, gc_calc;
  logic [2:0] bit_q, bit_d;
  logic [3:0] nib;
  logic [GROUP_W-1:0] word;
  logic hs;
  number_msn_finder #(.NUM_W(NUM_W)) u_msn (
    .num        (inNumber),
    .group_count(gc_calc)
  );
`ifdef LITERAL_HEADER_EN
  localparam logic [2:0] HDR_LAST = 3'(VERSION_W + 2);
  logic [VERSION_W-1:0] ver_q, ver_d;
  logic [VERSION_W+2:0] hdr;
  assign hdr = {ver_q, LIT_TYPE_ID} << bit_q;
  assign outBit = state_q == GROUP ? word[GROUP_W-1] : state_q == HEADER ? hdr[VERSION_W+2] : 1'b0;
`else
  logic unused_ver;
  assign unused_ver = ^inVersion;
  assign outBit = state_q == GROUP ? word[GROUP_W-1] : 1'b0;
`endif
  always_comb begin
    nib = '0;
    for (int i = 0; i < NUM_W / NIBBLE_W; i++)
      nib = grp_q == 5'(i) ? num_q[NIBBLE_W*i +: NIBBLE_W] : nib;
  end
  assign word       = {grp_q != 5'd0, nib} << bit_q;
  assign inReady    = state_q == IDLE;
  assign outValid   = state_q != IDLE;
  assign busy       = outValid;
  assign hs         = outValid && outReady;
  assign outLast    = state_q == GROUP && grp_q == 5'd0 && bit_q == 3'd4;
  assign groupCount = gc_q;
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    gc_d    = gc_q;
    grp_d   = grp_q;
    bit_d   = bit_q;
`ifdef LITERAL_HEADER_EN
    ver_d   = ver_q;
`endif
    case (state_q)
      IDLE: if (inValid) begin
`ifdef LITERAL_HEADER_EN
        state_d = HEADER;
        ver_d   = inVersion;
`else
        state_d = GROUP;
`endif
        num_d = inNumber;
        gc_d  = gc_calc;
        grp_d = gc_calc - 5'd1;
        bit_d = '0;
      end
`ifdef LITERAL_HEADER_EN
      HEADER: if (hs) begin
        bit_d   = bit_q == HDR_LAST ? 3'd0 : bit_q + 3'd1;
        state_d = bit_q == HDR_LAST ? GROUP : HEADER;
      end
`endif
      GROUP: if (hs) begin
        bit_d   = bit_q == 3'd4 ? 3'd0 : bit_q + 3'd1;
        grp_d   = bit_q == 3'd4 ? grp_q - 5'd1 : grp_q;
        state_d = bit_q == 3'd4 && grp_q == 5'd0 ? IDLE : GROUP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      num_q   <= '0;
      gc_q    <= '0;
      grp_q   <= '0;
      bit_q   <= '0;
`ifdef LITERAL_HEADER_EN
      ver_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      gc_q    <= gc_d;
      grp_q   <= grp_d;
      bit_q   <= bit_d;
`ifdef LITERAL_HEADER_EN
      ver_q   <= ver_d;
`endif
    end
  end
endmodule

// File: tb/tb_number_encoder.sv
// tb_number_encoder: directed vectors against a queue-based stream model plus literal expectations
module tb_number_encoder;
  logic clk = 0, reset = 1, inValid = 0, outReady = 1;
  logic inReady, outValid, outBit, outLast, busy;
  logic [63:0] inNumber = '0;
  logic [2:0] inVersion = '0;
  logic [4:0] groupCount;
  int pass_cnt = 0, total_cnt = 0;
  bit exp_q[$];
  bit got[$];
  bit held_v = 0;
  logic [1:0] held;
`ifdef LITERAL_HEADER_EN
  localparam int HB = 6;
`else
  localparam int HB = 0;
`endif
  always #5 clk = ~clk;
  number_encoder dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .inNumber(inNumber), .inVersion(inVersion), .outValid(outValid),
    .outReady(outReady), .outBit(outBit), .outLast(outLast),
    .groupCount(groupCount), .busy(busy)
  );
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [127:0] pack_got();
    logic [127:0] v = '0;
    foreach (got[i]) v = (v << 1) | 128'(got[i]);
    return v;
  endfunction
  function automatic logic [127:0] with_hdr(input logic [5:0] h, input logic [127:0] body, input int bl);
    return HB != 0 ? ((128'(h) << bl) | body) : body;
  endfunction
  always @(negedge clk) begin
    bit b;
    if (reset) held_v = 0;
    else begin
      if (held_v) check("hold", {outValid, outBit, outLast}, {1'b1, held});
      held_v = 0;
      if (!outValid) check("idle_zero", {outBit, outLast}, 2'b00);
      else if (outReady) begin
        if (exp_q.size() == 0) check("extra_bit", 1, 0);
        else begin
          b = exp_q.pop_front();
          check("bit", outBit, b);
          check("last", outLast, exp_q.size() == 0);
          got.push_back(outBit);
        end
      end else begin
        held = {outBit, outLast};
        held_v = 1;
      end
    end
  end
  task automatic start(input logic [63:0] n, input logic [2:0] v);
    int gc = 1;
    logic [3:0] nb;
    while (gc < 16 && (n >> (4 * gc)) != 0) gc++;
    @(posedge clk); #1;
    check("ready_before", inReady, 1);
    inValid = 1; inNumber = n; inVersion = v;
    got.delete(); exp_q.delete();
`ifdef LITERAL_HEADER_EN
    for (int b = 2; b >= 0; b--) exp_q.push_back(v[b]);
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
`endif
    for (int k = gc - 1; k >= 0; k--) begin
      nb = 4'(n >> (4 * k));
      exp_q.push_back(k > 0);
      for (int b = 3; b >= 0; b--) exp_q.push_back(nb[b]);
    end
    @(posedge clk); #1;
    inValid = 0; inNumber = ~n; inVersion = ~v;
    check("group_count_model", groupCount, gc);
    check("busy_ready", {busy, inReady}, 2'b10);
  endtask
  task automatic drain(input bit rnd);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 500) begin
      outReady = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    outReady = 1;
    check("drain_done", exp_q.size(), 0);
    check("ready_after", {inReady, busy, outValid}, 3'b100);
  endtask
  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {inReady, outValid, outBit, outLast, groupCount, busy}, {4'b1000, 5'd0, 1'b0});
    reset = 0;
    start(64'h7E5, 3'd6);
    check("gc_7e5", groupCount, 3);
    drain(0);
    check("len_7e5", got.size(), 15 + HB);
    check("stream_7e5", pack_got(), with_hdr(6'b110100, 128'(15'b101111111000101), 15));
    check("gc_hold", groupCount, 3);
    start(64'h0, 3'd0);
    check("gc_zero", groupCount, 1);
    drain(0);
    check("stream_zero", {32'(got.size()), pack_got()[95:0]}, {32'(5 + HB), 96'(with_hdr(6'b000100, 128'(5'b00000), 5))});
    start(64'hFFFF_FFFF_FFFF_FFFF, 3'd0);
    check("gc_full", groupCount, 16);
    drain(0);
    check("len_full", got.size(), 80 + HB);
    check("stream_full", pack_got(), with_hdr(6'b000100, 128'({{15{5'b11111}}, 5'b01111}), 80));
    start(64'h7E5, 3'd6);
    drain(1);
    check("len_stall", got.size(), 15 + HB);
    check("stream_stall", pack_got(), with_hdr(6'b110100, 128'(15'b101111111000101), 15));
    start(64'hABCD, 3'd5);
    cyc = 0;
    while (got.size() < 7 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("seven_bits", got.size(), 7);
    reset = 1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 0;
    check("abort_state", {outValid, inReady, busy, outLast}, 4'b0100);
    check("abort_gc", groupCount, 0);
    start(64'h1, 3'd0);
    drain(0);
    check("stream_one", {32'(got.size()), pack_got()[95:0]}, {32'(5 + HB), 96'(with_hdr(6'b000100, 128'(5'b00001), 5))});
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
